// File: rtl/traffic_pkg.sv
// Shared phase codes, lamp encodings and phase helpers for the traffic light path.
package traffic_pkg;

  localparam logic [2:0] NS_GREEN  = 3'd0;
  localparam logic [2:0] NS_YELLOW = 3'd1;
  localparam logic [2:0] RED_TO_EW = 3'd2;
  localparam logic [2:0] EW_GREEN  = 3'd3;
  localparam logic [2:0] EW_YELLOW = 3'd4;
  localparam logic [2:0] RED_TO_NS = 3'd5;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  typedef enum logic [2:0] {
    S_NS_GREEN  = NS_GREEN,
    S_NS_YELLOW = NS_YELLOW,
    S_RED_TO_EW = RED_TO_EW,
    S_EW_GREEN  = EW_GREEN,
    S_EW_YELLOW = EW_YELLOW,
    S_RED_TO_NS = RED_TO_NS
  } phase_e;

  // Returns {ns_lamp, ew_lamp}; anything unrecognised shows all-red.
  function automatic logic [5:0] lamps_for(input logic [2:0] ph);
    case (ph)
      NS_GREEN:  return {LAMP_GRN, LAMP_RED};
      NS_YELLOW: return {LAMP_YEL, LAMP_RED};
      EW_GREEN:  return {LAMP_RED, LAMP_GRN};
      EW_YELLOW: return {LAMP_RED, LAMP_YEL};
      default:   return {LAMP_RED, LAMP_RED};
    endcase
  endfunction

  function automatic logic is_transit(input logic [2:0] ph);
    return (ph == NS_YELLOW) || (ph == RED_TO_EW) ||
           (ph == EW_YELLOW) || (ph == RED_TO_NS);
  endfunction

endpackage

// File: rtl/traffic_phase_sequencer_timer.sv
// Per-phase cycle counter: cleared on phase entry, saturates at the phase limit.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt < limit) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt >= limit);

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Turns complementary NS/EW light requests into a timed green/yellow/all-red lamp sequence.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = 16,
  parameter int YELLOW    = 4,
  parameter int ALL_RED   = 2,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ns_req,
  input  logic       ew_req,
  output logic [2:0] ns_lamp,
  output logic [2:0] ew_lamp,
  output logic [2:0] phase,
  output logic       busy
);

  localparam logic [CNT_W-1:0] GREEN_LIM = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LIM   = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] RED_LIM   = CNT_W'(ALL_RED - 1);

  phase_e           state;
  phase_e           next_state;
  logic [CNT_W-1:0] limit;
  logic             done;
  logic             advance;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (advance),
    .limit (limit),
    .done  (done)
  );

  // Equal requests (00 or 11) never count as a request for the other direction.
  always_comb begin
    limit      = GREEN_LIM;
    advance    = 1'b0;
    next_state = S_NS_GREEN;
    case (state)
      S_NS_GREEN: begin
        advance    = done && ew_req && !ns_req;
        next_state = S_NS_YELLOW;
      end
      S_NS_YELLOW: begin
        limit      = YEL_LIM;
        advance    = done;
        next_state = S_RED_TO_EW;
      end
      S_RED_TO_EW: begin
        limit      = RED_LIM;
        advance    = done;
        next_state = S_EW_GREEN;
      end
      S_EW_GREEN: begin
        advance    = done && ns_req && !ew_req;
        next_state = S_EW_YELLOW;
      end
      S_EW_YELLOW: begin
        limit      = YEL_LIM;
        advance    = done;
        next_state = S_RED_TO_NS;
      end
      S_RED_TO_NS: begin
        limit      = RED_LIM;
        advance    = done;
        next_state = S_NS_GREEN;
      end
      default: begin
        advance    = 1'b1;
        next_state = S_NS_GREEN;
      end
    endcase
    if (!advance) begin
      next_state = state;
    end
  end

  // Lamps and busy are decoded from the next state so they change on the same edge as phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_NS_GREEN;
      phase   <= NS_GREEN;
      ns_lamp <= LAMP_GRN;
      ew_lamp <= LAMP_RED;
      busy    <= 1'b0;
    end else begin
      state              <= next_state;
      phase              <= next_state;
      {ns_lamp, ew_lamp} <= lamps_for(next_state);
      busy               <= is_transit(next_state);
    end
  end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Scoreboard bench: directed phase expectations per cycle plus invariant checks under random requests.
module tb_traffic_phase_sequencer;
  import traffic_pkg::*;

  localparam int MIN_GREEN = 16;
  localparam int YELLOW    = 4;
  localparam int ALL_RED   = 2;
  localparam int CNT_W     = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ns_req = 1'b0;
  logic       ew_req = 1'b0;
  logic [2:0] ns_lamp, ew_lamp, phase;
  logic       busy;

  traffic_phase_sequencer #(
    .MIN_GREEN (MIN_GREEN),
    .YELLOW    (YELLOW),
    .ALL_RED   (ALL_RED),
    .CNT_W     (CNT_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ns_req  (ns_req),
    .ew_req  (ew_req),
    .ns_lamp (ns_lamp),
    .ew_lamp (ew_lamp),
    .phase   (phase),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [9:0] val;
    string      name;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         t0 = 0;
  int         checks = 0;
  int         errors = 0;
  bit         prop_on = 1'b0;
  logic [2:0] prev_ph = 3'd0;
  int         run = 0;
  int         n_yel = 0;

  // Expected {phase, ns_lamp, ew_lamp, busy} from the phase table.
  function automatic logic [9:0] outs(input logic [2:0] ph);
    case (ph)
      3'd0:    return {ph, 3'b001, 3'b100, 1'b0};
      3'd1:    return {ph, 3'b010, 3'b100, 1'b1};
      3'd2:    return {ph, 3'b100, 3'b100, 1'b1};
      3'd3:    return {ph, 3'b100, 3'b001, 1'b0};
      3'd4:    return {ph, 3'b100, 3'b010, 1'b1};
      default: return {ph, 3'b100, 3'b100, 1'b1};
    endcase
  endfunction

  task automatic expect_at(input int k, input logic [2:0] ph, input string nm);
    exp_t e;
    e.cyc  = t0 + k;
    e.val  = outs(ph);
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic expect_reset(input int k, input string nm);
    exp_t e;
    e.cyc  = t0 + k;
    e.val  = {3'd0, 3'b001, 3'b100, 1'b0};
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic goto(input int k);
    while (cyc - t0 < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    t0 = cyc;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: scoreboard pops plus invariant checks while random stimulus runs.
  initial forever begin
    @(negedge clk);
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL %s: sample at cycle %0d was missed", sb[0].name, sb[0].cyc - t0);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if ({phase, ns_lamp, ew_lamp, busy} !== e.val) begin
        errors++;
        $display("FAIL %s: got phase/ns/ew/busy=%b required %b",
                 e.name, {phase, ns_lamp, ew_lamp, busy}, e.val);
      end
    end
    if (prop_on) begin
      checks++;
      if ((ns_lamp != 3'b100 && ew_lamp != 3'b100) || {phase, ns_lamp, ew_lamp, busy} !== outs(phase)) begin
        errors++;
        $display("FAIL safety_lamps: got phase/ns/ew/busy=%b required %b",
                 {phase, ns_lamp, ew_lamp, busy}, outs(phase));
      end
      if (phase == prev_ph) begin
        run++;
      end else begin
        bit ok;
        checks++;
        ok = (phase == ((prev_ph == 3'd5) ? 3'd0 : prev_ph + 3'd1));
        case (prev_ph)
          3'd0, 3'd3: ok = ok && (run >= MIN_GREEN);
          3'd1, 3'd4: begin
            ok = ok && (run == YELLOW);
            n_yel++;
          end
          default:    ok = ok && (run == ALL_RED);
        endcase
        if (!ok) begin
          errors++;
          $display("FAIL phase_duration: phase %0d -> %0d after %0d cycles", prev_ph, phase, run);
        end
        prev_ph = phase;
        run = 1;
      end
    end
  end

  initial begin
    logic [1:0] pat [4];
    pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b11; pat[3] = 2'b00;

    // NS->EW swap with request held from cycle 0, then EW dwell and toggling during transit.
    do_reset();
    ns_req = 1'b0;
    ew_req = 1'b1;
    expect_reset(0, "reset_state");
    expect_at(15, 3'd0, "ns_green_last");
    expect_at(16, 3'd1, "ns_yellow_first");
    expect_at(19, 3'd1, "ns_yellow_last");
    expect_at(20, 3'd2, "red_to_ew_first");
    expect_at(21, 3'd2, "red_to_ew_last");
    expect_at(22, 3'd3, "ew_green_entry");
    expect_at(28, 3'd3, "ew_short_pulse_ignored");
    expect_at(37, 3'd3, "ew_green_hold");
    expect_at(42, 3'd3, "ew_green_req_cycle");
    expect_at(43, 3'd4, "ew_yellow_next");
    expect_at(46, 3'd4, "ew_yellow_toggled_last");
    expect_at(47, 3'd5, "red_to_ns_first");
    expect_at(48, 3'd5, "red_to_ns_last");
    expect_at(49, 3'd0, "ns_green_reentry");
    expect_at(50, 3'd0, "ns_green_hold");
    goto(27);
    ns_req = 1'b1; ew_req = 1'b0;
    goto(28);
    ns_req = 1'b0; ew_req = 1'b1;
    goto(42);
    ns_req = 1'b1; ew_req = 1'b0;
    for (int k = 43; k <= 48; k++) begin
      goto(k);
      {ns_req, ew_req} = pat[(k - 43) % 4];
    end
    goto(49);
    ns_req = 1'b1; ew_req = 1'b0;
    goto(51);

    // Long NS hold, late request, then reset during the clearance interval.
    do_reset();
    ns_req = 1'b1; ew_req = 1'b0;
    expect_reset(0, "reset_state_2");
    expect_at(39, 3'd0, "ns_long_hold");
    expect_at(40, 3'd0, "ns_late_req_cycle");
    expect_at(41, 3'd1, "ns_yellow_late");
    expect_at(44, 3'd1, "ns_yellow_late_last");
    expect_at(45, 3'd2, "red_to_ew_before_reset");
    expect_reset(46, "mid_sequence_reset");
    goto(40);
    ns_req = 1'b0; ew_req = 1'b1;
    goto(45);
    reset = 1'b1;
    goto(46);
    reset = 1'b0;
    t0 = cyc;
    expect_at(1, 3'd0, "post_reset_green");
    expect_at(15, 3'd0, "post_reset_dwell_last");
    expect_at(16, 3'd1, "post_reset_yellow");
    goto(17);

    // Random requests with invariant checking.
    do_reset();
    prev_ph = 3'd0;
    run = 0;
    prop_on = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      #1;
      {ns_req, ew_req} = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    #1;
    prop_on = 1'b0;
    checks++;
    if (n_yel == 0) begin
      errors++;
      $display("FAIL random_yellow_seen: got %0d yellow phases required > 0", n_yel);
    end

    for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: expectation never reached, %0d left", sb[0].name, sb.size());
      void'(sb.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
